// File: rtl/shift_pkg.sv
// Shared constants for the 8-bit serial link: default word width and the
// bit-order encodings used by both the transmitter and this receiver.
package shift_pkg;

    localparam int SHIFT_WORD_W = 8;

    // Bit-order encodings, matching the shift_register transmitter
    localparam bit SHIFT_MSB_FIRST = 1'b1;
    localparam bit SHIFT_LSB_FIRST = 1'b0;

endpackage

// File: rtl/shift_deserializer_word_hold_reg.sv
// Single-entry holding register with a valid/ready output handshake.
// A load is accepted when the entry is empty or is being drained on the same
// edge; otherwise the offered word is refused and the old word is kept.
module word_hold_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             load_refused
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;
    logic             transfer;
    logic             can_accept;

    assign transfer   = valid_q & ready_in;
    assign can_accept = ~valid_q | ready_in;

    // Next-state: drain on transfer, refill if a word arrives while there is room
    always_comb begin
        data_d       = data_q;
        valid_d      = valid_q;
        load_refused = 1'b0;
        if (transfer) begin
            valid_d = 1'b0;
        end
        if (load) begin
            if (can_accept) begin
                data_d  = load_data;
                valid_d = 1'b1;
            end else begin
                load_refused = 1'b1;
            end
        end
    end

    // Storage for the buffered word and its occupancy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver. Assembles WIDTH-bit words from strobed
// serial bits, hands them to a one-word holding buffer, and raises a sticky
// overrun flag whenever a finished word has nowhere to go.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int WIDTH     = SHIFT_WORD_W,
    parameter bit MSB_FIRST = SHIFT_MSB_FIRST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     data_in,
    input  logic                     clear,
    output logic [WIDTH-1:0]         parallel_data_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic                     overrun,
    output logic [$clog2(WIDTH)-1:0] bit_count
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovr_q;
    logic             ovr_d;
    logic [WIDTH-1:0] shifted;
    logic             word_done;
    logic             hold_refused;

    // The completed word includes the bit sampled on this edge, so the
    // buffer is fed the shifted value rather than the current register.
    assign shifted   = MSB_FIRST ? {sr_q[WIDTH-2:0], data_in}
                                 : {data_in, sr_q[WIDTH-1:1]};
    assign word_done = enable & ~clear & (cnt_q == LAST_BIT);

    // Next-state for shifter, bit counter and overrun; clear beats enable
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        ovr_d = ovr_q;
        if (clear) begin
            sr_d  = '0;
            cnt_d = '0;
            ovr_d = 1'b0;
        end else begin
            if (enable) begin
                sr_d  = shifted;
                cnt_d = (cnt_q == LAST_BIT) ? '0 : cnt_q + 1'b1;
            end
            if (hold_refused) begin
                ovr_d = 1'b1;
            end
        end
    end

    // Receive-side state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
        end
    end

    word_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk         (clk),
        .rst         (rst),
        .load        (word_done),
        .load_data   (shifted),
        .ready_in    (ready_in),
        .data_out    (parallel_data_out),
        .valid_out   (valid_out),
        .load_refused(hold_refused)
    );

    assign overrun   = ovr_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed testbench for shift_deserializer. Two instances share control
// inputs: one receives MSB-first, the other LSB-first.
module tb_shift_deserializer;
    import shift_pkg::*;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       clear;
    logic       ready_in;
    logic       din_m;
    logic       din_l;

    logic [7:0] pdo_m;
    logic       vo_m;
    logic       ov_m;
    logic [2:0] bc_m;
    logic [7:0] pdo_l;
    logic       vo_l;
    logic       ov_l;
    logic [2:0] bc_l;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_m;
    logic [7:0] tx_l;

    shift_deserializer #(
        .WIDTH(SHIFT_WORD_W),
        .MSB_FIRST(SHIFT_MSB_FIRST)
    ) dut_msb (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .data_in          (din_m),
        .clear            (clear),
        .parallel_data_out(pdo_m),
        .valid_out        (vo_m),
        .ready_in         (ready_in),
        .overrun          (ov_m),
        .bit_count        (bc_m)
    );

    shift_deserializer #(
        .WIDTH(SHIFT_WORD_W),
        .MSB_FIRST(SHIFT_LSB_FIRST)
    ) dut_lsb (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .data_in          (din_l),
        .clear            (clear),
        .parallel_data_out(pdo_l),
        .valid_out        (vo_l),
        .ready_in         (ready_in),
        .overrun          (ov_l),
        .bit_count        (bc_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then advance past the next rising edge
    task automatic applyStimulus(input logic en, input logic dm, input logic dl,
                                 input logic clr, input logic rdy);
        enable   = en;
        din_m    = dm;
        din_l    = dl;
        clear    = clr;
        ready_in = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Send one byte, bit 7 first, to both receivers
    task automatic sendBits(input logic [7:0] b, input logic rdy);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, b[i], b[i], 1'b0, rdy);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("reset_data_m", 32'(pdo_m), 32'h00);
        checkOutput("reset_valid_m", 32'(vo_m), 32'h0);
        checkOutput("reset_ovr_m", 32'(ov_m), 32'h0);
        checkOutput("reset_cnt_m", 32'(bc_m), 32'h0);
        checkOutput("reset_data_l", 32'(pdo_l), 32'h00);
        rst = 1'b0;

        $display("[TB] test 1: 0xAA at full rate");
        sendBits(8'hAA, 1'b1);
        checkOutput("t1_data_m", 32'(pdo_m), 32'hAA);
        checkOutput("t1_valid_m", 32'(vo_m), 32'h1);
        checkOutput("t1_cnt_m", 32'(bc_m), 32'h0);
        checkOutput("t1_data_l", 32'(pdo_l), 32'h55);
        checkOutput("t1_valid_l", 32'(vo_l), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_valid_drop_m", 32'(vo_m), 32'h0);
        checkOutput("t1_valid_drop_l", 32'(vo_l), 32'h0);

        $display("[TB] test 2: gaps between bits");
        tx_m = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, tx_m[7-i], tx_m[7-i], 1'b0, 1'b1);
            if (i == 1 || i == 4) begin
                repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
                checkOutput("t2_gap_cnt_m", 32'(bc_m), 32'(i + 1));
                checkOutput("t2_gap_valid_m", 32'(vo_m), 32'h0);
            end
        end
        checkOutput("t2_data_m", 32'(pdo_m), 32'hAA);
        checkOutput("t2_data_l", 32'(pdo_l), 32'h55);
        checkOutput("t2_valid_l", 32'(vo_l), 32'h1);
        checkOutput("t2_cnt_l", 32'(bc_l), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] test 3: overrun with consumer stalled");
        sendBits(8'hAA, 1'b0);
        checkOutput("t3_first_valid_m", 32'(vo_m), 32'h1);
        checkOutput("t3_first_ovr_m", 32'(ov_m), 32'h0);
        sendBits(8'h0F, 1'b0);
        checkOutput("t3_held_data_m", 32'(pdo_m), 32'hAA);
        checkOutput("t3_held_valid_m", 32'(vo_m), 32'h1);
        checkOutput("t3_ovr_m", 32'(ov_m), 32'h1);
        checkOutput("t3_held_data_l", 32'(pdo_l), 32'h55);
        checkOutput("t3_ovr_l", 32'(ov_l), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t3_drain_valid_m", 32'(vo_m), 32'h0);
        checkOutput("t3_sticky_ovr_m", 32'(ov_m), 32'h1);

        $display("[TB] test 4: clear aborts partial word");
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t4_partial_cnt_m", 32'(bc_m), 32'h3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("t4_clear_cnt_m", 32'(bc_m), 32'h0);
        checkOutput("t4_clear_ovr_m", 32'(ov_m), 32'h0);
        checkOutput("t4_clear_ovr_l", 32'(ov_l), 32'h0);
        sendBits(8'hC3, 1'b1);
        checkOutput("t4_data_m", 32'(pdo_m), 32'hC3);
        checkOutput("t4_valid_m", 32'(vo_m), 32'h1);
        checkOutput("t4_cnt_m", 32'(bc_m), 32'h0);
        checkOutput("t4_ovr_m", 32'(ov_m), 32'h0);
        checkOutput("t4_data_l", 32'(pdo_l), 32'hC3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] test 5: reset mid-word with full buffer");
        sendBits(8'h3C, 1'b0);
        checkOutput("t5_prior_data_m", 32'(pdo_m), 32'h3C);
        tx_m = 8'b1011_0000;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, tx_m[7-i], tx_m[7-i], 1'b0, 1'b0);
        end
        checkOutput("t5_partial_cnt_m", 32'(bc_m), 32'h5);
        checkOutput("t5_prior_valid_m", 32'(vo_m), 32'h1);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("t5_rst_data_m", 32'(pdo_m), 32'h00);
        checkOutput("t5_rst_valid_m", 32'(vo_m), 32'h0);
        checkOutput("t5_rst_cnt_m", 32'(bc_m), 32'h0);
        checkOutput("t5_rst_ovr_m", 32'(ov_m), 32'h0);
        checkOutput("t5_rst_data_l", 32'(pdo_l), 32'h00);
        sendBits(8'h81, 1'b1);
        checkOutput("t5_after_data_m", 32'(pdo_m), 32'h81);
        checkOutput("t5_after_valid_m", 32'(vo_m), 32'h1);
        checkOutput("t5_after_data_l", 32'(pdo_l), 32'h81);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] test 6: loopback from transmitter model");
        tx_m = 8'h55;
        tx_l = 8'h55;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, tx_m[7], tx_l[0], 1'b0, 1'b1);
            tx_m = {tx_m[6:0], 1'b0};
            tx_l = {1'b0, tx_l[7:1]};
        end
        checkOutput("t6_loop_data_m", 32'(pdo_m), 32'h55);
        checkOutput("t6_loop_valid_m", 32'(vo_m), 32'h1);
        checkOutput("t6_loop_data_l", 32'(pdo_l), 32'h55);
        checkOutput("t6_loop_valid_l", 32'(vo_l), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
